// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
//
// Contents:
//   ctrl_state_e  sequencer states (IDLE, LOAD_W, STREAM, DRAIN, DONE)
//   ctrl_mask_w   width of the per-PE control masks (ROW*COL)
//   CTRL_MASK_W   mask width for the default 4x4 array
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_e;

  function automatic int ctrl_mask_w(input int rows, input int cols);
    return rows * cols;
  endfunction

  localparam int DEF_ROW     = 4;
  localparam int DEF_COL     = 4;
  localparam int CTRL_MASK_W = ctrl_mask_w(DEF_ROW, DEF_COL);

endpackage

// File: rtl/systolic_addr_cnt.sv
// Buffer address up-counter with synchronous clear and terminal-count flag.
//
// Ports:
//   clk_i   clock
//   rstn_i  synchronous active-low reset (count -> 0)
//   clr_i   synchronous clear, wins over en_i
//   en_i    count enable
//   last_i  terminal value; tc_o is high while cnt_o equals it
//   cnt_o   current count (a flop, usable directly as a registered address)
//   tc_o    terminal-count flag
module systolic_addr_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

  assign tc_o = (cnt_o == last_i);

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a ROW x COL systolic array: loads weights, streams pre-skewed
// input rows, drives the per-PE load / sum-out masks and writes the skewed
// south-edge results to the output buffer.
//
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds perf_cycles_o, a saturating
// count of busy cycles in the current or last job.
//
// Ports (all outputs registered, reset synchronous active-low):
//   clk_i, rstn_i            clock, reset
//   start_i, skip_load_i     start command (IDLE only), reuse resident weights
//   num_vec_i                vector count N, latched at an accepted start
//   busy_o, done_o           job in progress, one-cycle completion pulse
//   perf_cycles_o            busy-cycle counter (SYSTOLIC_CTRL_PERF_EN only)
//   wb_mem_ren_o/_addr_o     weight buffer read port
//   ib_mem_ren_o/_addr_o     input buffer read port
//   ob_mem_wen_o/_addr_o     output buffer write port
//   ctrl_load_o              per-PE weight-load mask
//   ctrl_sum_out_o           per-PE sum-out mask
module systolic_array_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ROW     = 4,
  parameter int COL     = 4,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8,
  parameter int OUT_LAT = ROW + 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 start_i,
  input  logic                 skip_load_i,
  input  logic [CNT_W-1:0]     num_vec_i,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef SYSTOLIC_CTRL_PERF_EN
  output logic [31:0]          perf_cycles_o,
`endif
  output logic                 wb_mem_ren_o,
  output logic [ADDR_W-1:0]    wb_mem_addr_o,
  output logic                 ib_mem_ren_o,
  output logic [ADDR_W-1:0]    ib_mem_addr_o,
  output logic                 ob_mem_wen_o,
  output logic [ADDR_W-1:0]    ob_mem_addr_o,
  output logic [ROW*COL-1:0]   ctrl_load_o,
  output logic [ROW*COL-1:0]   ctrl_sum_out_o
);

  localparam int MASK_W = ctrl_mask_w(ROW, COL);
  localparam int LAT_W  = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(OUT_LAT - 1);

  if (WIDTH < 1 || ROW < 1 || COL < 1 || OUT_LAT < 1) begin : g_bad_cfg
    $error("systolic_array_ctrl: WIDTH, ROW, COL and OUT_LAT must all be >= 1");
  end

  ctrl_state_e       state_q, state_d;
  logic              start_ok, busy_d, state_chg, stream_entry;
  logic [CNT_W-1:0]  n_q;
  logic [ADDR_W-1:0] wb_last, ib_last, ob_last;
  logic              wb_tc, ib_tc, ob_tc;
  logic              lat_run_q, ob_done_q;
  logic [LAT_W-1:0]  lat_cnt_q;

  // Terminal addresses: ROW weight rows, L = N+ROW-1 input rows,
  // W = N+COL-1 output words. Modular add keeps ROW/COL = 1 correct.
  assign wb_last = ADDR_W'(ROW - 1);
  assign ib_last = ADDR_W'(n_q) + ADDR_W'(ROW - 2);
  assign ob_last = ADDR_W'(n_q) + ADDR_W'(COL - 2);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          if (num_vec_i == '0)  state_d = DONE;
          else if (skip_load_i) state_d = STREAM;
          else                  state_d = LOAD_W;
        end
      end
      LOAD_W:  if (wb_tc)     state_d = STREAM;
      STREAM:  if (ib_tc)     state_d = DRAIN;
      DRAIN:   if (ob_done_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d == LOAD_W) || (state_d == STREAM) || (state_d == DRAIN);
    state_chg    = (state_d != state_q);
    stream_entry = (state_d == STREAM) && (state_q != STREAM);
  end

  systolic_addr_cnt #(.W(ADDR_W)) u_wb_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (state_chg),
    .en_i   (state_q == LOAD_W),
    .last_i (wb_last),
    .cnt_o  (wb_mem_addr_o),
    .tc_o   (wb_tc)
  );

  systolic_addr_cnt #(.W(ADDR_W)) u_ib_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (state_chg),
    .en_i   (state_q == STREAM),
    .last_i (ib_last),
    .cnt_o  (ib_mem_addr_o),
    .tc_o   (ib_tc)
  );

  // The write schedule can straddle STREAM -> DRAIN, so that one entry
  // must not clear the output address.
  systolic_addr_cnt #(.W(ADDR_W)) u_ob_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (state_chg && (state_d != DRAIN)),
    .en_i   (ob_mem_wen_o),
    .last_i (ob_last),
    .cnt_o  (ob_mem_addr_o),
    .tc_o   (ob_tc)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      wb_mem_ren_o   <= 1'b0;
      ib_mem_ren_o   <= 1'b0;
      ob_mem_wen_o   <= 1'b0;
      ctrl_load_o    <= '0;
      ctrl_sum_out_o <= '0;
      n_q            <= '0;
      lat_run_q      <= 1'b0;
      lat_cnt_q      <= '0;
      ob_done_q      <= 1'b0;
    end else begin
      busy_o       <= busy_d;
      done_o       <= (state_d == DONE);
      wb_mem_ren_o <= (state_d == LOAD_W);
      ib_mem_ren_o <= (state_d == STREAM);
      if (start_ok) n_q <= num_vec_i;

      // Masks trail the read enables by the buffer's one-cycle read latency.
      ctrl_load_o    <= {MASK_W{wb_mem_ren_o}};
      ctrl_sum_out_o <= {MASK_W{(ib_mem_ren_o | ctrl_sum_out_o[0]) & busy_d}};

      if (state_q == IDLE) begin
        lat_run_q    <= 1'b0;
        ob_mem_wen_o <= 1'b0;
        ob_done_q    <= 1'b0;
      end

      // First input read happens in the first STREAM cycle; lat_cnt_q counts
      // from there so the first write lands exactly OUT_LAT cycles later.
      if (stream_entry) begin
        lat_run_q <= 1'b1;
        lat_cnt_q <= '0;
        ob_done_q <= 1'b0;
      end else if (lat_run_q) begin
        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
        if (lat_cnt_q == LAT_LAST) begin
          lat_run_q    <= 1'b0;
          ob_mem_wen_o <= 1'b1;
        end
      end

      if (ob_mem_wen_o && ob_tc) begin
        ob_mem_wen_o <= 1'b0;
        ob_done_q    <= 1'b1;
      end
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      perf_cycles_o <= '0;
    end else if (start_ok) begin
      perf_cycles_o <= '0;
    end else if (busy_o && (perf_cycles_o != '1)) begin
      perf_cycles_o <= perf_cycles_o + 32'd1;
    end
  end
`endif

endmodule
